// File: rtl/rf_multiport_sb_pkg.sv
// Shared defaults for the multiport register file and its scoreboard.
// Widths here match the core's architectural register file.
package rf_multiport_sb_pkg;

    localparam int RF_DW       = 32;
    localparam int RF_NREG     = 32;
    localparam int RF_AW       = $clog2(RF_NREG);
    localparam int RF_NRD      = 2;
    localparam int RF_ZERO_REG = 1;

    // An address that the zero-register rule pins to zero.
    function automatic logic is_zero_addr(
        input logic [RF_AW-1:0] addr,
        input int               zero_reg
    );
        return (zero_reg != 0) && (addr == '0);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: flush beats issue, issue beats writeback.
// busy_vec is the raw registered state with no bypass applied.
module rf_scoreboard
    import rf_multiport_sb_pkg::*;
#(
    parameter  int NREG     = RF_NREG,
    parameter  int ZERO_REG = RF_ZERO_REG,
    localparam int AW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic            flush,
    output logic [NREG-1:0] busy_vec
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            iss_ok;

    assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (wr_en) begin
                busy_nxt[wr_addr] = 1'b0;
            end
            // A new producer supersedes a retiring one on the same register.
            if (iss_ok) begin
                busy_nxt[iss_addr] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy_vec = busy;

endmodule

// File: rtl/rf_multiport_sb.sv
// Parametrised register file: NRD async read ports with write-first bypass,
// one writeback port and a busy scoreboard for decode hazard detection.
module rf_multiport_sb
    import rf_multiport_sb_pkg::*;
#(
    parameter  int DW       = RF_DW,
    parameter  int NREG     = RF_NREG,
    parameter  int NRD      = RF_NRD,
    parameter  int ZERO_REG = RF_ZERO_REG,
    localparam int AW       = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              flush,
    output logic [NREG-1:0]   busy_vec
);

    logic [DW-1:0] regs [NREG];
    logic          wr_ok;

    assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    rf_scoreboard #(
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic          zero;
        logic          hit;
        logic          wb_same;

        assign addr    = rd_addr[i*AW +: AW];
        assign zero    = (ZERO_REG != 0) && (addr == '0);
        assign wb_same = wr_en && (wr_addr == addr);
        assign hit     = wr_ok && (wr_addr == addr);

        always_comb begin
            rd_data[i*DW +: DW] = regs[addr];
            if (zero) begin
                rd_data[i*DW +: DW] = '0;
            end else if (hit) begin
                rd_data[i*DW +: DW] = wr_data;
            end
        end

        // Same-cycle writeback resolves the hazard through the bypass.
        assign rd_busy[i] = busy_vec[addr] & ~wb_same & ~zero;
    end

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Self-checking bench: directed literal checks plus random traffic
// compared every cycle against a behavioural register/busy model.
module tb_rf_multiport_sb;

    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic              flush;
    logic [NREG-1:0]   busy_vec;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [DW-1:0] mreg  [NREG];
    logic          mbusy [NREG];

    always #5 clk = ~clk;

    rf_multiport_sb #(
        .DW       (DW),
        .NREG     (NREG),
        .NRD      (NRD),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Architectural model: x0 is hardwired, flush clears all,
    // otherwise a writeback retires and an issue then marks busy.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                mreg[r]  <= '0;
                mbusy[r] <= 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 0) mreg[wr_addr] <= wr_data;
            if (flush) begin
                for (int r = 0; r < NREG; r++) mbusy[r] <= 1'b0;
            end else begin
                if (wr_en) mbusy[wr_addr] <= 1'b0;
                if (iss_en && iss_addr != 0) mbusy[iss_addr] <= 1'b1;
            end
        end
    end

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wr_en && wr_addr == a) return wr_data;
        return mreg[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        return mbusy[a] && !(wr_en && wr_addr == a);
    endfunction

    function automatic logic [NREG-1:0] exp_vec();
        logic [NREG-1:0] v;
        for (int r = 0; r < NREG; r++) v[r] = mbusy[r];
        return v;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < NRD; i++) begin
                logic [AW-1:0] a;
                a = rd_addr[i*AW +: AW];
                chk($sformatf("model_rd_data%0d", i),
                    rd_data[i*DW +: DW], exp_data(a));
                chk($sformatf("model_rd_busy%0d", i),
                    {31'd0, rd_busy[i]}, {31'd0, exp_busy(a)});
            end
            chk("model_busy_vec", busy_vec, exp_vec());
        end
    end

    task automatic idle();
        wr_en  = 1'b0;
        iss_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_addr = '0;
        idle();
        next();
        cmp_en = 1'b1;
        rd_addr = {5'd5, 5'd0};
        #2;
        chk("rst_rd0_x0", rd_data[31:0], 32'h0);
        chk("rst_rd1_x5", rd_data[63:32], 32'h0);
        chk("rst_busy", {30'd0, rd_busy}, 32'h0);
        chk("rst_busy_vec", busy_vec, 32'h0);
        rd_addr = {5'd31, 5'd31};
        #1;
        chk("rst_rd_x31", rd_data[31:0], 32'h0);
        rst = 1'b0;

        next();
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'hDEADBEEF;
        rd_addr = {5'd0, 5'd7};
        #2;
        chk("bypass_x7", rd_data[31:0], 32'hDEADBEEF);
        next();
        idle();
        #2;
        chk("stored_x7", rd_data[31:0], 32'hDEADBEEF);

        next();
        wr_en = 1'b1; wr_addr = 0; wr_data = 32'h1234;
        iss_en = 1'b1; iss_addr = 0;
        rd_addr = {5'd0, 5'd0};
        #2;
        chk("zero_rd", rd_data[31:0], 32'h0);
        chk("zero_busy", {31'd0, rd_busy[0]}, 32'h0);
        next();
        idle();
        #2;
        chk("zero_rd_after", rd_data[63:32], 32'h0);
        chk("zero_busy_vec0", {31'd0, busy_vec[0]}, 32'h0);

        next();
        iss_en = 1'b1; iss_addr = 3;
        rd_addr = {5'd3, 5'd0};
        #2;
        chk("iss_x3_N", {31'd0, rd_busy[1]}, 32'h0);
        next();
        idle();
        #2;
        chk("iss_x3_N1", {31'd0, rd_busy[1]}, 32'h1);
        next();
        next();
        wr_en = 1'b1; wr_addr = 3; wr_data = 32'h55;
        #2;
        chk("wb_x3_busy", {31'd0, rd_busy[1]}, 32'h0);
        chk("wb_x3_data", rd_data[63:32], 32'h55);
        next();
        idle();
        #2;
        chk("wb_x3_vec", {31'd0, busy_vec[3]}, 32'h0);

        iss_en = 1'b1; iss_addr = 9;
        wr_en = 1'b1; wr_addr = 9; wr_data = 32'h99;
        next();
        idle();
        #2;
        chk("iss_wins_x9", {31'd0, busy_vec[9]}, 32'h1);
        flush = 1'b1; iss_en = 1'b1; iss_addr = 4;
        next();
        idle();
        #2;
        chk("flush_vec", busy_vec, 32'h0);

        wr_en = 1'b1; wr_addr = 10; wr_data = 32'hA5;
        iss_en = 1'b1; iss_addr = 10;
        rd_addr = {5'd10, 5'd10};
        next();
        idle();
        #2;
        chk("x10_busy_pre", {31'd0, busy_vec[10]}, 32'h1);
        chk("x10_data_pre", rd_data[31:0], 32'hA5);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_vec", busy_vec, 32'h0);
        chk("async_rst_x10", rd_data[31:0], 32'h0);
        #1;
        rst = 1'b0;
        next();
        wr_en = 1'b1; wr_addr = 10; wr_data = 32'h77;
        next();
        idle();
        #2;
        chk("post_rst_wr", rd_data[63:32], 32'h77);

        for (int n = 0; n < 3000; n++) begin
            next();
            wr_en    = $urandom_range(0, 1);
            wr_addr  = AW'($urandom_range(0, 11));
            wr_data  = $urandom;
            iss_en   = $urandom_range(0, 1);
            iss_addr = AW'($urandom_range(0, 11));
            flush    = ($urandom_range(0, 15) == 0);
            rd_addr  = {AW'($urandom_range(0, 11)),
                        AW'($urandom_range(0, 11))};
        end
        next();
        idle();
        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_multiport_sb.md
Name: rf_multiport_sb

Overview:
- Parametrised successor to the single-write, dual-read pipeline register file.
- Generalised in data width, register count and read-port count.
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard for pipeline hazard detection.
- Sits between decode (read and issue) and writeback (write and clear) in the pipelined core.

Parameters:
- DW, 32, data width in bits.
- NREG, 32, number of architectural registers (power of two, at least 2).
- AW, log2(NREG), register address width (derived localparam).
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never busy.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- rd_addr  in  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NRD*DW  packed read data, combinational.
- rd_busy  out  NRD  per-port flag: the addressed register has an outstanding producer.
- wr_en  in  1  writeback enable.
- wr_addr  in  AW  writeback address.
- wr_data  in  DW  writeback data.
- iss_en  in  1  issue of an instruction that will write iss_addr.
- iss_addr  in  AW  destination register of the issuing instruction.
- flush  in  1  pipeline flush; clears all busy bits.
- busy_vec  out  NREG  registered scoreboard state, for debug and hazard-unit use.

Behaviour:
- Reset (async, rst=1): all NREG data registers are 0 and all busy bits are 0. This holds immediately and while rst stays high.
- Reset effect on outputs: rd_data reads 0 for every port (unless a combinational bypass applies), rd_busy=0, busy_vec=0.
- Write: on a rising edge with wr_en=1, reg[wr_addr] <= wr_data. This is suppressed when ZERO_REG=1 and wr_addr=0.
- Read: asynchronous, zero latency. rd_data[i] = reg[rd_addr[i]].
- Bypass: if wr_en=1, wr_addr==rd_addr[i] and the write is not suppressed, then rd_data[i] = wr_data in the same cycle (write-first).
- Zero register: with ZERO_REG=1, rd_addr[i]==0 always gives rd_data[i]=0 and rd_busy[i]=0.
- Multiple read ports on the same address return identical data and busy values.
- Scoreboard next-state, evaluated per register r each clock edge in this priority order:
  1. flush=1 -> busy[r]<=0 for all r; any iss_en in the same cycle is ignored.
  2. iss_en=1 and iss_addr==r -> busy[r]<=1. Set wins over a same-cycle writeback clear to the same register, because the new producer supersedes the old one.
  3. wr_en=1 and wr_addr==r -> busy[r]<=0.
  4. Otherwise busy[r] holds.
  - iss_addr=0 with ZERO_REG=1 has no effect.
- rd_busy[i] = busy[rd_addr[i]] & ~(wr_en & wr_addr==rd_addr[i]). Writeback in the same cycle resolves the hazard through the bypass.
- Issue affects rd_busy from the next cycle only.
- Writeback to a non-busy register is legal: data is written and busy stays 0. No error is flagged.
- busy_vec is the registered busy array with no bypass applied. busy_vec[0] is tied to 0 when ZERO_REG=1.
- Reset asserted mid-operation clears all state regardless of wr_en, iss_en or flush. The first edge after rst deasserts behaves as normal.
- No X propagation: out-of-range addresses cannot occur because NREG = 2^AW.

Decomposition:
- Shared package/defines header: default DW, NREG, AW and the ZERO_REG default. Reuse the codebase's existing register-width defines where present.
- One natural sub-module: rf_scoreboard, holding the busy array, the flush/issue/writeback priority logic and the busy_vec output.
- The top level holds the storage array, the read muxes and the bypass comparators. The read/bypass port logic is a generate loop over NRD, not a separate sub-module.

Test Plan:
- Reset then read all ports at addresses 0, 5, 31 -> rd_data=0, rd_busy=0, busy_vec=0.
- Write 0xDEADBEEF to x7 with rd_addr[0]=7 in the same cycle -> rd_data[0]=0xDEADBEEF that cycle (bypass). Next cycle, with wr_en=0 -> still 0xDEADBEEF.
- With ZERO_REG=1: write 0x1234 to x0 and issue to x0 -> rd_data for x0 = 0, rd_busy=0, busy_vec[0]=0.
- Issue x3 at cycle N -> rd_busy for x3 = 0 at N and 1 at N+1. Writeback x3=0x55 at N+3 -> rd_busy=0 and rd_data=0x55 at N+3; busy_vec[3]=0 at N+4.
- Same cycle, issue x9 and writeback x9 -> busy_vec[9]=1 next cycle. Flush plus issue x4 in the same cycle -> busy_vec=0 next cycle.
- Assert rst asynchronously between edges while x10 is busy and holds 0xA5 -> busy_vec=0 and x10 reads 0 before the next edge. After release, normal writes resume.
